// File: rtl/vga_fmap_display_if.sv
// Read bus between the feature-map viewer and the upstream convolution RAM.
// rd_data is expected exactly one clock after the matching rd_en/rd_addr.
interface vga_fmap_display_if #(
  parameter int DATA_W = 20,
  parameter int ADDR_W = 13
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport master (output rd_en, output rd_addr, input rd_data);
  modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/vga_fmap_display.sv
// Loads an IMG_W x IMG_H activation map into a frame buffer (binary threshold or,
// with VGA_GRAY_EN defined, 16-level grayscale) and shows it as a 640x480 VGA window.
module vga_fmap_display #(
  parameter int IMG_W      = 62,
  parameter int IMG_H      = 82,
  parameter int DATA_W     = 20,
  parameter int ADDR_W     = 13,
  parameter int X0         = 289,
  parameter int Y0         = 199,
  parameter int SCALE_LOG2 = 0,
  parameter int PIX_DIV    = 4,
  parameter int H_SYNC     = 96,
  parameter int H_ACT_S    = 144,
  parameter int H_ACT_E    = 784,
  parameter int H_TOT      = 800,
  parameter int V_SYNC     = 2,
  parameter int V_ACT_S    = 35,
  parameter int V_ACT_E    = 515,
  parameter int V_TOT      = 525
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [2:0]          thr_sel,
  input  logic                gray_mode,
  input  logic [DATA_W-1:0]   max_pl,
  vga_fmap_display_if.master  rd,
  output logic                done,
  output logic [11:0]         vga,
  output logic                HS,
  output logic                VS,
  output logic                hFree,
  output logic                vFree
);

  localparam int N  = IMG_W * IMG_H;
  localparam int CW = $clog2((H_TOT > V_TOT) ? H_TOT : V_TOT) + 1;
  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int TW = DATA_W + 3;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, SHOW} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        thr_q, thr_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0]     div_q, div_d;
  logic [CW-1:0]     x_q, x_d, y_q, y_d;
  logic              hs_p_q, hs_p_d, vs_p_q, vs_p_d, hf_p_q, hf_p_d, vf_p_q, vf_p_d;
  logic              win_p_q, win_p_d;
  logic              hs_q, hs_d, vs_q, vs_d, hf_q, hf_d, vf_q, vf_d;
  logic [11:0]       vga_q, vga_d;
  logic [11:0]       fb_rd_q;
  logic [11:0]       fb_mem [0:(1<<ADDR_W)-1];

  logic [TW-1:0]     thr_full;
  logic [11:0]       pix_bin, pix;
  logic              tick, in_win;
  logic [CW-1:0]     x_off, y_off;
  logic [ADDR_W-1:0] win_addr;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    thr_d   = thr_q;
    max_d   = max_q;
    case (state_q)
      IDLE, SHOW: if (start) begin
        state_d = LOAD;
        addr_d  = '0;
        thr_d   = thr_sel;
        max_d   = max_pl;
      end
      LOAD: if (addr_q == ADDR_W'(N - 1)) begin
        state_d = DRAIN;
        addr_d  = '0;
      end else begin
        addr_d = addr_q + ADDR_W'(1);
      end
      DRAIN:   state_d = SHOW;
      default: state_d = IDLE;
    endcase
  end

  assign rd.rd_en   = (state_q == LOAD);
  assign rd.rd_addr = addr_q;
  assign done       = (state_q == SHOW);
  assign wr_en_d    = rd.rd_en;
  assign wr_addr_d  = addr_q;

  // Threshold kept at full DATA_W+3 width so max*7 never wraps before the divide by 8.
  assign thr_full = (TW'(max_q) * TW'(thr_q)) >> 3;
  assign pix_bin  = (TW'(rd.rd_data) > thr_full) ? 12'h000 : 12'hFFF;

`ifdef VGA_GRAY_EN
  localparam int MW = $clog2(DATA_W);
  logic              gray_q, gray_d;
  logic [MW-1:0]     msb, shift;
  logic [DATA_W-1:0] shifted;
  logic [3:0]        level;

  always_comb begin
    gray_d = gray_q;
    if ((state_q == IDLE || state_q == SHOW) && start) gray_d = gray_mode;
  end

  // Scale so the top four bits below max's leading one select the gray level.
  always_comb begin
    msb = '0;
    for (int i = 0; i < DATA_W; i++)
      if (max_q[i]) msb = MW'(i);
    shift   = (msb > MW'(3)) ? msb - MW'(3) : '0;
    shifted = rd.rd_data >> shift;
    level   = (shifted > DATA_W'(15)) ? 4'hF : shifted[3:0];
    if (!gray_q)           pix = pix_bin;
    else if (max_q == '0)  pix = 12'hFFF;
    else                   pix = {3{4'hF - level}};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) gray_q <= 1'b0;
    else        gray_q <= gray_d;
  end
`else
  logic unused_gray_mode;
  assign unused_gray_mode = gray_mode;
  assign pix = pix_bin;
`endif

  always_comb begin
    tick  = (div_q == DW'(PIX_DIV - 1));
    div_d = tick ? '0 : div_q + DW'(1);
    x_d   = x_q;
    y_d   = y_q;
    if (tick) begin
      if (x_q == CW'(H_TOT - 1)) begin
        x_d = '0;
        y_d = (y_q == CW'(V_TOT - 1)) ? '0 : y_q + CW'(1);
      end else begin
        x_d = x_q + CW'(1);
      end
    end
  end

  // Stage 1 looks up the buffer and sync flags; stage 2 registers the outputs.
  always_comb begin
    in_win   = (x_q >= CW'(X0)) && (x_q < CW'(X0 + (IMG_W << SCALE_LOG2))) &&
               (y_q >= CW'(Y0)) && (y_q < CW'(Y0 + (IMG_H << SCALE_LOG2)));
    x_off    = x_q - CW'(X0);
    y_off    = y_q - CW'(Y0);
    win_addr = in_win ? ADDR_W'(y_off >> SCALE_LOG2) * ADDR_W'(IMG_W) + ADDR_W'(x_off >> SCALE_LOG2)
                      : '0;
    hs_p_d   = (x_q >= CW'(H_SYNC));
    vs_p_d   = (y_q >= CW'(V_SYNC));
    hf_p_d   = (x_q >= CW'(H_ACT_S)) && (x_q < CW'(H_ACT_E));
    vf_p_d   = (y_q >= CW'(V_ACT_S)) && (y_q < CW'(V_ACT_E));
    win_p_d  = in_win && (state_q == SHOW);
    hs_d     = hs_p_q;
    vs_d     = vs_p_q;
    hf_d     = hf_p_q;
    vf_d     = vf_p_q;
    vga_d    = win_p_q ? fb_rd_q : 12'h000;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      thr_q     <= '0;
      max_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      div_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      hs_p_q    <= 1'b1;
      vs_p_q    <= 1'b1;
      hf_p_q    <= 1'b0;
      vf_p_q    <= 1'b0;
      win_p_q   <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      hf_q      <= 1'b0;
      vf_q      <= 1'b0;
      vga_q     <= 12'h000;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      thr_q     <= thr_d;
      max_q     <= max_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      div_q     <= div_d;
      x_q       <= x_d;
      y_q       <= y_d;
      hs_p_q    <= hs_p_d;
      vs_p_q    <= vs_p_d;
      hf_p_q    <= hf_p_d;
      vf_p_q    <= vf_p_d;
      win_p_q   <= win_p_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      hf_q      <= hf_d;
      vf_q      <= vf_d;
      vga_q     <= vga_d;
    end
  end

  // Buffer is deliberately left out of reset; separate write and display ports.
  always_ff @(posedge clk) begin
    if (wr_en_q) fb_mem[wr_addr_q] <= pix;
    fb_rd_q <= fb_mem[win_addr];
  end

  assign vga   = vga_q;
  assign HS    = hs_q;
  assign VS    = vs_q;
  assign hFree = hf_q;
  assign vFree = vf_q;

endmodule

// File: tb/tb_vga_fmap_display.sv
// Randomised bench for vga_fmap_display: buffer contents, load latency and raster
// outputs are compared against an arithmetic model of the viewer.
module tb_vga_fmap_display;

  localparam int IMG_W = 62, IMG_H = 82, DATA_W = 20, ADDR_W = 13;
  localparam int X0 = 289, Y0 = 2, SCALE_LOG2 = 1, ZOOM = 2, PIX_DIV = 4;
  localparam int H_SYNC = 96, H_ACT_S = 144, H_ACT_E = 784, H_TOT = 800;
  localparam int V_SYNC = 2, V_ACT_S = 35, V_ACT_E = 515, V_TOT = 525;
  localparam int N = IMG_W * IMG_H;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [2:0]        thr_sel = '0;
  logic              gray_mode = 1'b0;
  logic [DATA_W-1:0] max_pl = '0;
  logic              done, HS, VS, hFree, vFree;
  logic [11:0]       vga;

  vga_fmap_display_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) rd_bus ();

  vga_fmap_display #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .X0(X0), .Y0(Y0), .SCALE_LOG2(SCALE_LOG2), .PIX_DIV(PIX_DIV),
    .H_SYNC(H_SYNC), .H_ACT_S(H_ACT_S), .H_ACT_E(H_ACT_E), .H_TOT(H_TOT),
    .V_SYNC(V_SYNC), .V_ACT_S(V_ACT_S), .V_ACT_E(V_ACT_E), .V_TOT(V_TOT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .thr_sel(thr_sel),
    .gray_mode(gray_mode), .max_pl(max_pl), .rd(rd_bus), .done(done),
    .vga(vga), .HS(HS), .VS(VS), .hFree(hFree), .vFree(vFree)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] ram    [0:(1<<ADDR_W)-1];
  logic [11:0]       fb_exp [0:N-1];

  // Conv RAM: data one clock after a read strobe, noise otherwise.
  always @(posedge clk)
    rd_bus.rd_data <= rd_bus.rd_en ? ram[rd_bus.rd_addr] : DATA_W'($urandom);

  int checks = 0, errors = 0;
  int edge_cnt;
  bit mon_en = 1'b0;
  int show_on_edge = 1 << 30;
  int e0, sel;
  logic [DATA_W-1:0] mx;

  always @(posedge clk or negedge reset)
    if (!reset) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] pixelModel(input longint data, input int s, input bit gray,
                                             input longint m);
    bit     use_gray;
    longint thr, lvl;
    int     k, sh;
`ifdef VGA_GRAY_EN
    use_gray = gray;
`else
    use_gray = 1'b0 & gray;
`endif
    if (use_gray) begin
      if (m == 0) return 12'hFFF;
      k = 0;
      for (longint v = m; v > 1; v = v / 2) k++;
      sh  = (k > 3) ? k - 3 : 0;
      lvl = data / (longint'(1) << sh);
      if (lvl > 15) lvl = 15;
      return 12'((15 - lvl) * 'h111);
    end
    thr = (m * s) / 8;
    return (data > thr) ? 12'h000 : 12'hFFF;
  endfunction

  task automatic fillRam(input int kind, input logic [DATA_W-1:0] m);
    for (int i = 0; i < N; i++)
      case (kind)
        0:       ram[i] = DATA_W'(i);
        1:       ram[i] = DATA_W'($urandom_range(0, int'(m) * 2 + 1));
        default: ram[i] = DATA_W'($urandom >> $urandom_range(0, 31));
      endcase
  endtask

  task automatic computeExp(input int s, input bit gray, input logic [DATA_W-1:0] m);
    for (int i = 0; i < N; i++)
      fb_exp[i] = pixelModel(longint'(ram[i]), s, gray, longint'(m));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rd_en"}, rd_bus.rd_en, 0);
    checkOutput({tag, "_rd_addr"}, rd_bus.rd_addr, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_vga"}, vga, 0);
    checkOutput({tag, "_sync"}, {HS, VS, hFree, vFree}, 4'b1100);
  endtask

  task automatic applyStimulus(input int s, input bit gray, input logic [DATA_W-1:0] m,
                               input bit was_show, output int e);
    @(posedge clk); #1;
    start = 1'b1; thr_sel = 3'(s); gray_mode = gray; max_pl = m;
    e = edge_cnt;
    @(posedge clk); #1;
    start = 1'b0; thr_sel = 3'($urandom); gray_mode = 1'($urandom); max_pl = DATA_W'($urandom);
    if (was_show) checkOutput("done_fall", done, 0);
    checkOutput("load_rd_en", rd_bus.rd_en, 1);
    checkOutput("load_rd_addr", rd_bus.rd_addr, 0);
  endtask

  task automatic waitDone(input string tag, input int e, input bit poke);
    int seen = -1;
    for (int c = 0; c < N + 64; c++) begin
      @(negedge clk);
      if (poke && c == 40) begin
        start = 1'b1; thr_sel = ~thr_sel; max_pl = DATA_W'($urandom);
      end
      if (poke && c == 41) start = 1'b0;
      if (done) begin
        seen = edge_cnt - e;
        break;
      end
    end
    checkOutput(tag, seen, N + 2);
  endtask

  task automatic checkBuffer(input string tag);
    for (int i = 0; i < N; i++)
      checkOutput($sformatf("%s[%0d]", tag, i), dut.fb_mem[i], fb_exp[i]);
  endtask

  // Raster reference: output after edge t shows pixel (t-2)/PIX_DIV of the frame.
  int  m_p, m_x, m_y, m_a;
  bit  m_win;
  logic [11:0] m_exp;
  always @(negedge clk) begin
    if (mon_en && edge_cnt >= 2 && (edge_cnt % PIX_DIV) == 0) begin
      m_p = (edge_cnt - 2) / PIX_DIV;
      m_x = m_p % H_TOT;
      m_y = (m_p / H_TOT) % V_TOT;
      checkOutput("sync", {HS, VS, hFree, vFree},
                  {m_x >= H_SYNC, m_y >= V_SYNC, m_x >= H_ACT_S && m_x < H_ACT_E,
                   m_y >= V_ACT_S && m_y < V_ACT_E});
      m_win = m_x >= X0 && m_x < X0 + IMG_W * ZOOM && m_y >= Y0 && m_y < Y0 + IMG_H * ZOOM;
      if ((edge_cnt - show_on_edge) > 8 || (show_on_edge - edge_cnt) > 8) begin
        m_a   = ((m_y - Y0) / ZOOM) * IMG_W + (m_x - X0) / ZOOM;
        m_exp = (m_win && edge_cnt > show_on_edge) ? fb_exp[m_a] : 12'h000;
        checkOutput("vga", vga, m_exp);
      end
    end
  end

  initial begin
    #1 reset = 1'b0;
    #2 checkResetValues("reset");
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    mon_en = 1'b1;

    // Ramp map; load runs while window row 2 is scanned, so it must stay dark.
    fillRam(0, 1000);
    computeExp(5, 1'b0, 1000);
    while (edge_cnt < 5000) @(posedge clk);
    applyStimulus(5, 1'b0, 1000, 1'b0, e0);
    show_on_edge = e0 + N + 2;
    waitDone("lat_ramp", e0, 1'b0);
    checkBuffer("fb_ramp");
    checkOutput("fb_625", dut.fb_mem[625], 12'hFFF);
    checkOutput("fb_626", dut.fb_mem[626], 12'h000);
    while (edge_cnt < 6 * H_TOT * PIX_DIV + 4) @(posedge clk);
    mon_en = 1'b0;

    // Reload from SHOW; a start pulse mid-load must be ignored.
    sel = $urandom_range(1, 7);
    mx  = DATA_W'($urandom_range(1, (1 << DATA_W) - 1));
    fillRam(1, mx);
    computeExp(sel, 1'b0, mx);
    applyStimulus(sel, 1'b0, mx, 1'b1, e0);
    waitDone("lat_reload", e0, 1'b1);
    checkBuffer("fb_reload");

    // Grayscale point (binary with thr_sel=0 when grayscale is not built in).
    fillRam(2, 20'h00FFF);
    ram[2048] = 20'h00800;
    ram[0]    = '0;
    computeExp(0, 1'b1, 20'h00FFF);
    applyStimulus(0, 1'b1, 20'h00FFF, 1'b1, e0);
    waitDone("lat_gray", e0, 1'b0);
    checkBuffer("fb_gray");
`ifdef VGA_GRAY_EN
    checkOutput("fb_2048", dut.fb_mem[2048], 12'h777);
`else
    checkOutput("fb_2048", dut.fb_mem[2048], 12'h000);
`endif

    // max_pl = 0 with random data.
    sel = $urandom_range(0, 7);
    fillRam(2, '0);
    computeExp(sel, 1'b1, '0);
    applyStimulus(sel, 1'b1, '0, 1'b1, e0);
    waitDone("lat_max0", e0, 1'b0);
    checkBuffer("fb_max0");

    // Reset at address 100 of a load, then a clean reload.
    mx = DATA_W'($urandom);
    fillRam(1, mx);
    applyStimulus(3, 1'b0, mx, 1'b1, e0);
    begin
      bit found = 1'b0;
      for (int c = 0; c < 400 && !found; c++) begin
        @(negedge clk);
        if (rd_bus.rd_addr == ADDR_W'(100)) found = 1'b1;
      end
      checkOutput("abort_at_100", found, 1);
    end
    reset = 1'b0;
    #1 checkResetValues("abort");
    @(negedge clk);
    reset = 1'b1;
    sel = $urandom_range(0, 7);
    mx  = DATA_W'($urandom);
    fillRam(1, mx);
    computeExp(sel, 1'b0, mx);
    applyStimulus(sel, 1'b0, mx, 1'b0, e0);
    waitDone("lat_after_reset", e0, 1'b0);
    checkBuffer("fb_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/vga_fmap_display.md
# vga_fmap_display

Parametrised feature-map viewer: after a `start` pulse it streams an `IMG_W`×`IMG_H` activation map out of the upstream convolution RAM and quantises each word against the supplied max-pool value. Results go into an internal frame buffer, which is then shown as a window on a 640×480 VGA raster. Successor to the fixed single-threshold viewer: single clock domain (pixel-enable tick instead of derived clocks), selectable threshold ratio, integer zoom, reloadable, optional grayscale.

## Interface
- `IMG_W`, 62, map width in pixels
- `IMG_H`, 82, map height in pixels
- `DATA_W`, 20, activation/max word width
- `ADDR_W`, 13, read/frame-buffer address width (2^ADDR_W ≥ IMG_W·IMG_H)
- `X0`, 289 / `Y0`, 199, raw counter position of window top-left
- `SCALE_LOG2`, 0, zoom = 2^SCALE_LOG2 per axis
- `PIX_DIV`, 4, clk cycles per pixel tick
- `H_SYNC` 96, `H_ACT_S` 144, `H_ACT_E` 784, `H_TOT` 800, horizontal timing in pixels
- `V_SYNC` 2, `V_ACT_S` 35, `V_ACT_E` 515, `V_TOT` 525, vertical timing in lines

Ports:
- `clk` in 1, system clock
- `reset` in 1, asynchronous, active-low
- `start` in 1, single-cycle request to (re)load the map
- `thr_sel` in 3, threshold = max·thr_sel/8; sampled on accepted `start`
- `gray_mode` in 1, 1 = grayscale, 0 = binary; sampled on accepted `start`
- `max_pl` in DATA_W, max-pool value; sampled on accepted `start`
- `rd_en` out 1, read strobe to conv RAM
- `rd_addr` out ADDR_W, read address
- `rd_data` in DATA_W, valid exactly 1 clk after `rd_en`
- `done` out 1, frame buffer loaded and displayed
- `vga` out 12, {R,G,B} 4 bits each
- `HS`, `VS` out 1, sync, active-low
- `hFree`, `vFree` out 1, inside active horizontal/vertical region

## Operation
- States: IDLE → LOAD → DRAIN → SHOW.
- IDLE: `start`=1 latches `thr_sel`, `gray_mode`, `max_pl` → LOAD.
- LOAD: `rd_en`=1 every cycle; `rd_addr` counts 0…N−1 (N = IMG_W·IMG_H). On the cycle issuing N−1 → DRAIN.
- DRAIN: last word written; next cycle → SHOW.
- SHOW: `done`=1. `start` → LOAD (reload); `done` drops the cycle after `start`.
- `start` during LOAD/DRAIN is ignored.
- Write path: address = `rd_addr` delayed 1 clk, qualified by delayed `rd_en`.
- Binary: threshold = (max_pl·thr_sel)>>3, computed at DATA_W+3 bits, no truncation. Pixel = 12'h000 if `rd_data` > threshold, else 12'hFFF. thr_sel=0 → any nonzero word is black.
- Grayscale: shift = max(msb(max_pl)−3, 0); level = min(`rd_data`>>shift, 15); pixel = {3{4'hF−level}}. max_pl=0 → all pixels 12'hFFF.
- Raster: pixel tick every `PIX_DIV` clk. x counts 0…H_TOT−1 and wraps. y increments on x wrap and wraps at V_TOT−1.
- HS low for x<H_SYNC; VS low for y<V_SYNC. hFree = H_ACT_S≤x<H_ACT_E; vFree likewise.
- Window: X0≤x<X0+(IMG_W<<SCALE_LOG2) and Y0≤y<Y0+(IMG_H<<SCALE_LOG2).
- Window address = ((y−Y0)>>SCALE_LOG2)·IMG_W + ((x−X0)>>SCALE_LOG2).
- `vga` = buffer word inside window when state=SHOW; 0 otherwise, including in blanking.

## Timing
- Reset (`reset`=0, async): state IDLE, counters 0, `rd_en`=0, `rd_addr`=0, `done`=0, `vga`=0, `HS`=`VS`=1, `hFree`=`vFree`=0. Buffer contents are not cleared.
- Reset mid-LOAD aborts the load; the next `start` reloads from address 0.
- Load latency: `start` to `done`=1 takes N+2 clk.
- Frame buffer read has 1 clk latency. `vga` is registered 2 clk after the counter update. `HS`, `VS`, `hFree` and `vFree` are delayed 2 clk so all raster outputs stay aligned.
- Write and display read use separate ports. During a reload the display shows 0, so there is no read/write hazard.

## Configuration
- `VGA_GRAY_EN` defined: grayscale datapath and msb encoder compiled in; `gray_mode` behaves as above.
- Undefined: `gray_mode` ignored, binary only, encoder absent.

## Test plan
- Ramp map with rd_data = address, max_pl=1000, thr_sel=5 (threshold 625), binary → buffer words 0–625 are 12'hFFF, 626+ are 12'h000; `done` exactly N+2 clk after `start`.
- Raster check, PIX_DIV=4 → HS low for 384 clk per 3200-clk line; VS low for 2 lines of 525; `vga`=0 outside the window and before `done`.
- SCALE_LOG2=1 → each buffer word spans a 2×2 pixel block; x=X0+2 maps to address 1.
- Grayscale (`VGA_GRAY_EN`), max_pl=20'h00FFF, rd_data=20'h00800 → shift 8, level 8, pixel 12'h777.
- Drop `reset` to 0 at address 100 of LOAD → outputs at reset values immediately; next `start` reloads from 0 and completes in N+2 clk.
- `start` pulsed during LOAD → ignored; `start` in SHOW → `done` falls, reload runs with new thr_sel.
